// File: rtl/stream_demux1x2.sv
// rtl/stream_demux1x2.sv - 1-to-2 valid/ready stream demux with per-output register stage and beat counters
// Optional build macro: DEMUX_AUTO_TOGGLE_EN (destination alternates out0/out1, in_sel ignored)
module stream_demux1x2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state0;
    state_t           r_state1;
    state_t           w_state0_nx;
    state_t           w_state1_nx;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_sel;
    logic w_can_load0;
    logic w_can_load1;
    logic w_in_hs;
    logic w_load0;
    logic w_load1;

`ifdef DEMUX_AUTO_TOGGLE_EN
    logic r_toggle;
    logic w_unused_sel;

    assign w_unused_sel = in_sel;
    assign w_sel        = r_toggle;

    // Alternate destination on every accepted beat, starting with out0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle <= 1'b0;
        end else if (w_in_hs) begin
            r_toggle <= ~r_toggle;
        end
    end
`else
    assign w_sel = in_sel;
`endif

    // A stage can take a beat when empty, or when its current beat leaves this cycle
    assign w_can_load0 = (r_state0 == EMPTY) || out0_ready;
    assign w_can_load1 = (r_state1 == EMPTY) || out1_ready;
    assign in_ready    = w_sel ? w_can_load1 : w_can_load0;
    assign w_in_hs     = in_valid && in_ready;
    assign w_load0     = w_in_hs && !w_sel;
    assign w_load1     = w_in_hs && w_sel;

    // Next-state for both output stages: a load wins over a drain so the stage stays full
    always_comb begin
        w_state0_nx = r_state0;
        w_state1_nx = r_state1;
        if (w_load0) begin
            w_state0_nx = FULL;
        end else if ((r_state0 == FULL) && out0_ready) begin
            w_state0_nx = EMPTY;
        end
        if (w_load1) begin
            w_state1_nx = FULL;
        end else if ((r_state1 == FULL) && out1_ready) begin
            w_state1_nx = EMPTY;
        end
    end

    // State registers; reset drops any buffered beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state0 <= EMPTY;
            r_state1 <= EMPTY;
        end else begin
            r_state0 <= w_state0_nx;
            r_state1 <= w_state1_nx;
        end
    end

    // Data capture and acceptance counters, counted on input handshakes only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            if (w_load0) begin
                r_data0 <= in_data;
                r_cnt0  <= r_cnt0 + CNT_W'(1);
            end
            if (w_load1) begin
                r_data1 <= in_data;
                r_cnt1  <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign out0_valid = (r_state0 == FULL);
    assign out1_valid = (r_state1 == FULL);
    assign out0_data  = r_data0;
    assign out1_data  = r_data1;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_stream_demux1x2.sv
// tb/tb_stream_demux1x2.sv - directed self-checking bench for stream_demux1x2
module tb_stream_demux1x2;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int errors = 0;
    int checks = 0;

    stream_demux1x2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so inputs change away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_in_ready_sel0", in_ready, 1);
        in_sel = 1'b1;
        #1;
        chk("rst_in_ready_sel1", in_ready, 1);

`ifdef DEMUX_AUTO_TOGGLE_EN
        // Auto toggle: in_sel held at 1, routing alternates out0/out1
        step();
        in_sel   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_data = 8'h02;
        @(negedge clk);
        chk("tog_b1_out0_valid", out0_valid, 1);
        chk("tog_b1_out0_data", out0_data, 8'h01);
        chk("tog_b1_out1_valid", out1_valid, 0);
        step();
        in_data = 8'h03;
        @(negedge clk);
        chk("tog_b2_out1_valid", out1_valid, 1);
        chk("tog_b2_out1_data", out1_data, 8'h02);
        step();
        in_data = 8'h04;
        @(negedge clk);
        chk("tog_b3_out0_data", out0_data, 8'h03);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("tog_b4_out1_data", out1_data, 8'h04);
        chk("tog_cnt0", cnt0, 2);
        chk("tog_cnt1", cnt1, 2);
`else
        // Steering
        step();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_sel   = 1'b0;
        #1;
        chk("steer_in_ready", in_ready, 1);
        step();
        in_data = 8'h3C;
        in_sel  = 1'b1;
        @(negedge clk);
        chk("steer_out0_valid", out0_valid, 1);
        chk("steer_out0_data", out0_data, 8'hA5);
        chk("steer_out1_valid_early", out1_valid, 0);
        chk("steer_cnt0", cnt0, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("steer_out1_valid", out1_valid, 1);
        chk("steer_out1_data", out1_data, 8'h3C);
        chk("steer_out0_drained", out0_valid, 0);
        chk("steer_cnt1", cnt1, 1);

        // Backpressure isolation
        step();
        do_reset();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h11;
        in_sel     = 1'b0;
        step();
        in_data = 8'h99;
        #1;
        chk("bp_in_ready_stalled", in_ready, 0);
        in_sel  = 1'b1;
        in_data = 8'h22;
        #1;
        chk("bp_in_ready_other", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out0_held_valid", out0_valid, 1);
        chk("bp_out0_held_data", out0_data, 8'h11);
        chk("bp_out1_data", out1_data, 8'h22);
        chk("bp_out1_valid", out1_valid, 1);
        step();
        out0_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_out0_drained", out0_valid, 0);
        chk("bp_out1_drained", out1_valid, 0);
        chk("bp_cnt0", cnt0, 1);
        chk("bp_cnt1", cnt1, 1);

        // Back-to-back throughput to out0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'b0;
            in_data  = 8'(i);
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
            if (i > 0) begin
                chk("b2b_out0_valid", out0_valid, 1);
                chk("b2b_out0_data", out0_data, 32'(i - 1));
            end
            if (i == 15) chk("b2b_cnt0_15", cnt0, 15);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_data", out0_data, 8'h0F);
        chk("b2b_cnt0_wrap", cnt0, 0);

        // Counter wrap on out1, then reset with a stalled beat
        step();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'b1;
            in_data  = 8'(8'h40 + i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_cnt1", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);
        chk("wrap_last_data", out1_data, 8'h4F);
        step();
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h77;
        step();
        in_data = 8'h55;
        @(negedge clk);
        chk("mid_out1_valid", out1_valid, 1);
        chk("mid_out1_data", out1_data, 8'h77);
        chk("mid_cnt1", cnt1, 1);
        out1_ready = 1'b1;
        rst        = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out1_valid", out1_valid, 0);
        chk("mid_rst_out1_data", out1_data, 0);
        chk("mid_rst_cnt1", cnt1, 0);
        step();
        @(negedge clk);
        chk("mid_rst_idle_valid", out1_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
